// File: rtl/note_sequencer.sv
// note_sequencer: score-playback controller feeding the speaker note dividers.
//
// Fetches one stereo note word per beat from a synchronous score ROM and holds
// it for BEAT_CYCLES clocks. It supports an optional articulation gap at the end
// of each note, as well as pause (play low), stop (pulse) and loop control.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   play           level: 1 = run, 0 = pause
//   stop           one-cycle pulse: abort and rewind to address 0
//   loop_en        wrap to address 0 after the last score word
//   gap_en         force the final GAP_CYCLES of each note to silence
//   rom_addr       score ROM address
//   rom_rd         score ROM read strobe (data valid one cycle later)
//   rom_data       [43:22] left divider, [21:0] right divider (0 = rest)
//   note_div_left  left divider to the speaker (0 = silence)
//   note_div_right right divider to the speaker (0 = silence)
//   playing        high in FETCH, LOAD and PLAY
//   beat_idx       address of the note currently sounding
//   done           one-cycle pulse at the end of a non-looping score
module note_sequencer #(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000,
    parameter int unsigned SCORE_LEN   = 512,
    parameter int unsigned ADDR_W      = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              gap_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [43:0]       rom_data,
    output logic [21:0]       note_div_left,
    output logic [21:0]       note_div_right,
    output logic              playing,
    output logic [ADDR_W-1:0] beat_idx,
    output logic              done
);

    localparam int unsigned CntW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CntW-1:0]   LastCnt  = CntW'(BEAT_CYCLES - 1);
    localparam logic [CntW-1:0]   GapStart = CntW'(BEAT_CYCLES - GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(SCORE_LEN - 1);
    // With no gap configured GapStart would wrap, so the compare is disabled.
    localparam bit                GapUsed  = (GAP_CYCLES > 0);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay,
        StPause
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [21:0]       note_left_q, note_left_d;
    logic [21:0]       note_right_q, note_right_d;
    logic [21:0]       out_left_q, out_left_d;
    logic [21:0]       out_right_q, out_right_d;
    logic [ADDR_W-1:0] beat_idx_q, beat_idx_d;
    logic              rom_rd_q, rom_rd_d;
    logic              playing_q, playing_d;
    logic              done_q, done_d;
    logic              gap_active;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        note_left_d  = note_left_q;
        note_right_d = note_right_q;
        beat_idx_d   = beat_idx_q;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (play) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // A fetch always completes; play is re-checked in LOAD.
                state_d = StLoad;
            end
            StLoad: begin
                note_left_d  = rom_data[43:22];
                note_right_d = rom_data[21:0];
                beat_idx_d   = addr_q;
                cnt_d        = '0;
                state_d      = play ? StPlay : StPause;
            end
            StPlay: begin
                if (!play) begin
                    state_d = StPause;
                end else if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (addr_q != LastAddr) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = StFetch;
                    end else if (loop_en) begin
                        addr_d  = '0;
                        state_d = StFetch;
                    end else begin
                        done_d       = 1'b1;
                        addr_d       = '0;
                        note_left_d  = '0;
                        note_right_d = '0;
                        beat_idx_d   = '0;
                        state_d      = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPause: begin
                if (play) begin
                    state_d = StPlay;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Stop overrides every simultaneous event, including end of score.
        if (stop) begin
            state_d      = StIdle;
            addr_d       = '0;
            cnt_d        = '0;
            note_left_d  = '0;
            note_right_d = '0;
            beat_idx_d   = '0;
            done_d       = 1'b0;
        end
    end

    // Outputs are computed for the upcoming cycle and registered.
    assign gap_active = GapUsed && gap_en && (cnt_d >= GapStart);

    always_comb begin
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        rom_rd_d    = 1'b0;
        playing_d   = 1'b0;

        unique case (state_d)
            StIdle: begin
                out_left_d  = '0;
                out_right_d = '0;
            end
            StFetch: begin
                // Previous note stays on the speaker to avoid a glitch.
                rom_rd_d  = 1'b1;
                playing_d = 1'b1;
            end
            StLoad: begin
                playing_d = 1'b1;
            end
            StPlay: begin
                playing_d   = 1'b1;
                out_left_d  = gap_active ? '0 : note_left_d;
                out_right_d = gap_active ? '0 : note_right_d;
            end
            StPause: begin
                out_left_d  = '0;
                out_right_d = '0;
            end
            default: begin
                out_left_d  = '0;
                out_right_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            cnt_q        <= '0;
            note_left_q  <= '0;
            note_right_q <= '0;
            out_left_q   <= '0;
            out_right_q  <= '0;
            beat_idx_q   <= '0;
            rom_rd_q     <= 1'b0;
            playing_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            note_left_q  <= note_left_d;
            note_right_q <= note_right_d;
            out_left_q   <= out_left_d;
            out_right_q  <= out_right_d;
            beat_idx_q   <= beat_idx_d;
            rom_rd_q     <= rom_rd_d;
            playing_q    <= playing_d;
            done_q       <= done_d;
        end
    end

    assign rom_addr       = addr_q;
    assign rom_rd         = rom_rd_q;
    assign note_div_left  = out_left_q;
    assign note_div_right = out_right_q;
    assign playing        = playing_q;
    assign beat_idx       = beat_idx_q;
    assign done           = done_q;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Score-playback controller that drives the left/right note-divider inputs of the speaker datapath.
- Fetches one stereo note word per beat from an external synchronous score ROM and holds each note for a programmed number of clock cycles.
- Supports an optional articulation gap at the end of each note, plus pause, stop and loop control.
- Sits between the user-control logic (debounced buttons/switches) and the speaker's note_div_left/note_div_right inputs.

Parameters:
- BEAT_CYCLES, 12_500_000: clocks a note is held in PLAY (8 beats/s at 100 MHz).
- GAP_CYCLES, 1_250_000: final PLAY cycles forced to rest when gap_en=1; must be < BEAT_CYCLES.
- SCORE_LEN, 512: number of score words; last address is SCORE_LEN-1.
- ADDR_W, 9: ROM address width; must satisfy 2^ADDR_W >= SCORE_LEN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- play  in  1  level; 1 = run, 0 = pause
- stop  in  1  one-cycle pulse; abort playback and rewind to address 0
- loop_en  in  1  1 = wrap to address 0 after the last word
- gap_en  in  1  1 = enable the articulation gap
- rom_addr  out  ADDR_W  score ROM address
- rom_rd  out  1  ROM read strobe
- rom_data  in  44  [43:22] left divider, [21:0] right divider; valid exactly 1 cycle after rom_rd; a divider field of 0 = rest
- note_div_left  out  22  to speaker; 0 = silence
- note_div_right  out  22  to speaker; 0 = silence
- playing  out  1  high in FETCH, LOAD and PLAY
- beat_idx  out  ADDR_W  address of the note currently sounding
- done  out  1  one-cycle pulse at the end of the score when loop_en=0

Behaviour:
- States: IDLE, FETCH, LOAD, PLAY, PAUSE. All outputs and state are registered.
- Reset (asynchronous, effective immediately): state=IDLE, addr=0, beat counter=0, note regs=0; all outputs 0.
- IDLE: outputs 0; rom_rd=0. play=1 and stop=0 -> FETCH.
- FETCH (1 cycle): rom_rd=1, rom_addr=addr -> LOAD.
- LOAD (1 cycle): latch rom_data into the note regs; beat_idx<=addr; cnt<=0 -> PLAY.
- Start latency: play sampled high in IDLE at cycle 0 -> FETCH cycle 1 -> LOAD cycle 2 -> new note on note_div_* from cycle 3.
- Note period is BEAT_CYCLES+2 cycles.
- During FETCH/LOAD the previous note is held on the outputs, so there is no glitch between notes.
- PLAY:
  - cnt increments every cycle.
  - Outputs = note regs, except forced to 0 when gap_en=1 and cnt >= BEAT_CYCLES-GAP_CYCLES.
  - At cnt == BEAT_CYCLES-1, end of beat:
    - addr < SCORE_LEN-1: addr+1 -> FETCH.
    - addr == SCORE_LEN-1 and loop_en=1: addr<=0 -> FETCH.
    - addr == SCORE_LEN-1 and loop_en=0: done=1 for that cycle; addr<=0; note regs cleared -> IDLE.
- Pause:
  - play=0 while in PLAY -> PAUSE next cycle. cnt is frozen, outputs are 0, playing=0.
  - play=1 in PAUSE -> PLAY, resuming at the frozen cnt with the same note.
  - play falling in FETCH/LOAD: the fetch completes, then enter PAUSE instead of PLAY.
- Stop:
  - stop=1 in any state -> IDLE next cycle; addr=0, cnt=0, note regs cleared, outputs 0.
  - stop beats every simultaneous event, including play=1 and end-of-beat.
  - done is not asserted on stop.
- loop_en and gap_en are sampled live; a change takes effect at the next decision point or compare.
- Counter width is clog2(BEAT_CYCLES). cnt never exceeds BEAT_CYCLES-1, and addr never exceeds SCORE_LEN-1.
- A rest word passes through unchanged: 0 output, with timing identical to a normal note.

Test Plan:
- BEAT_CYCLES=8, GAP_CYCLES=2, SCORE_LEN=4, ROM[i]={22'd(100+i),22'd(200+i)}, gap_en=0, loop_en=0. Raise play at cycle 0 -> rom_rd at cycle 1 (addr 0); note_div_left=100 and right=200 from cycle 3 to cycle 10; next note 101/201 from cycle 13; done pulses once at the end of beat 3; outputs 0 and state IDLE afterwards.
- Same setup, gap_en=1 -> each note shows its value for 6 cycles, then 0 for 2 cycles, then holds during FETCH/LOAD.
- Same setup, loop_en=1 -> after addr 3 the sequence fetches addr 0 with no done pulse; 100/200 reappears 10 cycles after 103/203 started.
- Drop play at cnt=3 of note 1 for 20 cycles -> outputs 0 and playing=0 throughout; on resume 101/201 plays for exactly 5 more cycles.
- Assert stop in the same cycle as the end of beat 2 with play=1 -> IDLE next cycle, outputs 0, no done pulse; the next play restarts at addr 0.
- Assert rst asynchronously mid-PLAY -> all outputs 0 before the next clock edge; after release the block stays IDLE until play is sampled high.
